// File: rtl/ddr3_read_checker_if.sv
// ddr3_read_checker_if: read-data stream plus run control/status bundle for ddr3_read_checker.
interface ddr3_read_checker_if #(parameter int DATA_W = 64);
  logic              start;
  logic [31:0]       seed;
  logic [7:0]        num_bursts;
  logic [DATA_W-1:0] read_data;
  logic              read_data_valid;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [15:0]       err_count;
  logic [15:0]       first_err_beat;
  logic [7:0]        err_bytes;
  modport master (
    output start, seed, num_bursts, read_data, read_data_valid,
    input  busy, done, pass, timeout, err_count, first_err_beat, err_bytes
  );
  modport slave (
    input  start, seed, num_bursts, read_data, read_data_valid,
    output busy, done, pass, timeout, err_count, first_err_beat, err_bytes
  );
endinterface

// File: rtl/ddr3_read_checker.sv
// ddr3_read_checker: checks DDR3 read beats against an LFSR pattern {lfsr, ~lfsr}.
// Optional sticky per-byte mismatch map is built when DDR3_CHK_BYTE_ERR_EN is defined.
module ddr3_read_checker #(
  parameter int          DATA_W  = 64,
  parameter int          BEATS   = 4,
  parameter int          TIMEOUT = 4096,
  parameter logic [31:0] SEED    = 32'hA5A5_0001
) (
  input logic clk,
  input logic rst,
  ddr3_read_checker_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t            r_state, w_next;
  logic [31:0]       r_lfsr;
  logic [9:0]        r_total, r_beat_cnt, w_total;
  logic [WD_W-1:0]   r_wdog;
  logic              r_flush, r_timeout;
  logic              r_s1_vld, r_s1_mis;
  logic [15:0]       r_s1_idx, r_err_count, r_first;
  logic              w_start, w_acc, w_last, w_expire;
  logic [DATA_W-1:0] w_diff;
  assign w_start  = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_acc    = r_state == RUN && bus.read_data_valid;
  assign w_last   = w_acc && r_beat_cnt == r_total - 10'd1;
  assign w_expire = r_state == RUN && !bus.read_data_valid && r_wdog == WD_W'(TIMEOUT - 1);
  assign w_total  = 10'(32'(bus.num_bursts) * BEATS);
  assign w_diff   = bus.read_data ^ {r_lfsr, ~r_lfsr};
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = w_start ? (bus.num_bursts == 8'd0 ? FLUSH : RUN) : r_state;
      RUN:        w_next = (w_last || w_expire) ? FLUSH : RUN;
      FLUSH:      w_next = r_flush ? DONE : FLUSH;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_lfsr      <= SEED;
      r_total     <= '0;
      r_beat_cnt  <= '0;
      r_wdog      <= '0;
      r_flush     <= 1'b0;
      r_timeout   <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_mis    <= 1'b0;
      r_s1_idx    <= '0;
      r_err_count <= '0;
      r_first     <= 16'hFFFF;
    end else begin
      r_flush  <= r_state == FLUSH && !r_flush;
      r_s1_vld <= w_acc;
      r_s1_mis <= |w_diff;
      r_s1_idx <= 16'(r_beat_cnt);
      if (w_start) begin
        r_lfsr      <= bus.seed == 32'd0 ? SEED : bus.seed;
        r_total     <= w_total;
        r_beat_cnt  <= '0;
        r_wdog      <= '0;
        r_timeout   <= 1'b0;
        r_err_count <= '0;
        r_first     <= 16'hFFFF;
      end else if (r_state == RUN) begin
        if (w_acc) begin
          r_lfsr     <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
          r_beat_cnt <= r_beat_cnt + 10'd1;
          r_wdog     <= '0;
        end else if (w_expire) r_timeout <= 1'b1;
        else r_wdog <= r_wdog + 1'b1;
      end
      // Stage 2 only sees beats taken in RUN, so it never overlaps an accepted start.
      if (r_s1_vld && r_s1_mis) begin
        r_err_count <= r_err_count == 16'hFFFF ? r_err_count : r_err_count + 16'd1;
        r_first     <= r_first == 16'hFFFF ? r_s1_idx : r_first;
      end
    end
`ifdef DDR3_CHK_BYTE_ERR_EN
  logic [7:0] w_bytes, r_s1_bytes, r_err_bytes;
  always_comb begin
    w_bytes = '0;
    for (int i = 0; i < 8; i++) w_bytes[i] = |w_diff[8*i +: 8];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1_bytes  <= '0;
      r_err_bytes <= '0;
    end else begin
      r_s1_bytes  <= w_bytes;
      r_err_bytes <= w_start ? 8'h00 : (r_s1_vld ? r_err_bytes | r_s1_bytes : r_err_bytes);
    end
  assign bus.err_bytes = r_err_bytes;
`else
  assign bus.err_bytes = 8'h00;
`endif
  assign bus.busy           = r_state == RUN || r_state == FLUSH;
  assign bus.done           = r_state == DONE;
  assign bus.pass           = r_state == DONE && r_err_count == 16'd0 && !r_timeout;
  assign bus.timeout        = r_timeout;
  assign bus.err_count      = r_err_count;
  assign bus.first_err_beat = r_first;
endmodule

// File: tb/tb_ddr3_read_checker.sv
// tb_ddr3_read_checker: directed scoreboard bench; expected run results queued at start, checked at done.
module tb_ddr3_read_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ddr3_read_checker_if #(.DATA_W(64)) bus ();
  ddr3_read_checker #(.DATA_W(64), .BEATS(4), .TIMEOUT(16), .SEED(32'hA5A5_0001)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  typedef struct {
    logic        pass;
    logic        to;
    logic [15:0] ec;
    logic [15:0] feb;
    logic [7:0]  eb;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_lfsr;
  int m_idx;
`ifdef DDR3_CHK_BYTE_ERR_EN
  localparam logic [7:0] EB_BYTE2 = 8'h04;
`else
  localparam logic [7:0] EB_BYTE2 = 8'h00;
`endif
  function automatic logic [31:0] nxt(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_pass"}, 64'(bus.pass), 64'd0);
    chk({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
    chk({tag, "_err_count"}, 64'(bus.err_count), 64'd0);
    chk({tag, "_first_err"}, 64'(bus.first_err_beat), 64'hFFFF);
    chk({tag, "_err_bytes"}, 64'(bus.err_bytes), 64'd0);
  endtask
  task automatic pulse_start(input logic [31:0] s, input logic [7:0] nb);
    bus.start = 1'b1;
    bus.seed = s;
    bus.num_bursts = nb;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic begin_run(input logic [31:0] s, input logic [7:0] nb, input logic p, input logic to,
                           input logic [15:0] ec, input logic [15:0] feb, input logic [7:0] eb);
    exp_t e;
    e.pass = p; e.to = to; e.ec = ec; e.feb = feb; e.eb = eb;
    sb.push_back(e);
    m_lfsr = s == 32'd0 ? 32'hA5A5_0001 : s;
    m_idx = 0;
    pulse_start(s, nb);
    chk("busy_after_start", 64'(bus.busy), 64'd1);
  endtask
  task automatic send_beats(input int n, input int bad, input logic [63:0] mask);
    for (int i = 0; i < n; i++) begin
      bus.read_data = {m_lfsr, ~m_lfsr} ^ (m_idx == bad ? mask : 64'd0);
      bus.read_data_valid = 1'b1;
      tick();
      m_lfsr = nxt(m_lfsr);
      m_idx++;
    end
    bus.read_data_valid = 1'b0;
  endtask
  task automatic stray(input int n);
    for (int i = 0; i < n; i++) begin
      bus.read_data = {$urandom, $urandom};
      bus.read_data_valid = 1'b1;
      tick();
    end
    bus.read_data_valid = 1'b0;
  endtask
  task automatic finish_run(input string tag);
    exp_t e;
    for (int i = 0; i < 100 && !bus.done; i++) tick();
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pass"}, 64'(bus.pass), 64'(e.pass));
      chk({tag, "_timeout"}, 64'(bus.timeout), 64'(e.to));
      chk({tag, "_err_count"}, 64'(bus.err_count), 64'(e.ec));
      chk({tag, "_first_err"}, 64'(bus.first_err_beat), 64'(e.feb));
      chk({tag, "_err_bytes"}, 64'(bus.err_bytes), 64'(e.eb));
    end
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end
  initial begin
    bus.start = 1'b0;
    bus.seed = '0;
    bus.num_bursts = '0;
    bus.read_data = '0;
    bus.read_data_valid = 1'b0;
    repeat (3) tick();
    check_reset("rst");
    rst = 1'b0;
    tick();
    stray(3);
    check_reset("idle_stray");
    begin_run(32'h0000_0001, 8'd2, 1'b1, 1'b0, 16'd0, 16'hFFFF, 8'h00);
    send_beats(8, -1, 64'd0);
    chk("clean_lat0_done", 64'(bus.done), 64'd0);
    tick();
    chk("clean_lat1_done", 64'(bus.done), 64'd0);
    chk("clean_lat1_busy", 64'(bus.busy), 64'd1);
    tick();
    chk("clean_lat2_done", 64'(bus.done), 64'd1);
    finish_run("clean");
    begin_run(32'h1234_5678, 8'd4, 1'b0, 1'b0, 16'd1, 16'd5, EB_BYTE2);
    send_beats(16, 5, 64'h0000_0000_0010_0000);
    finish_run("corrupt");
    begin_run(32'hDEAD_BEEF, 8'd1, 1'b0, 1'b1, 16'd0, 16'hFFFF, 8'h00);
    send_beats(2, -1, 64'd0);
    finish_run("timeout");
    stray(2);
    chk("done_stray_done", 64'(bus.done), 64'd1);
    chk("done_stray_err", 64'(bus.err_count), 64'd0);
    begin_run(32'h0BAD_F00D, 8'd2, 1'b1, 1'b0, 16'd0, 16'hFFFF, 8'h00);
    send_beats(3, -1, 64'd0);
    pulse_start(32'h1111_2222, 8'd5);
    send_beats(5, -1, 64'd0);
    finish_run("restart_ignored");
    begin_run(32'd0, 8'd1, 1'b1, 1'b0, 16'd0, 16'hFFFF, 8'h00);
    send_beats(4, -1, 64'd0);
    finish_run("seed_zero");
    begin_run(32'h5555_0000, 8'd0, 1'b1, 1'b0, 16'd0, 16'hFFFF, 8'h00);
    finish_run("zero_len");
    m_lfsr = 32'h0000_0007;
    m_idx = 0;
    pulse_start(32'h0000_0007, 8'd2);
    send_beats(3, 1, 64'hFF);
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    begin_run(32'h0000_0042, 8'd1, 1'b1, 1'b0, 16'd0, 16'hFFFF, 8'h00);
    send_beats(4, -1, 64'd0);
    finish_run("after_rst");
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
